// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle Moore controller that sequences the register-file / ALU
// datapath. It accepts one command per valid/ready handshake and steps it through
// operand loads, execute and writeback. Every output is decoded from the state
// register and the fields latched at acceptance.
// Optional feature: define CTRL_MOVIMM_EN to add the move-immediate (MOVI) path.
module alu_seq_ctrl #(
    parameter int W          = 16,
    parameter int RW         = 3,
    parameter int SKIP_A_MVN = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [RW-1:0] cmd_rd,
    input  logic [RW-1:0] cmd_rn,
    input  logic [RW-1:0] cmd_rm,
    input  logic          cmd_mov,
    input  logic [W-1:0]  cmd_imm,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic          vsel,
    output logic [1:0]    ALUop,
    output logic [W-1:0]  datapath_in,
    output logic          done
);

`ifdef CTRL_MOVIMM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4,
        MOVI = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_t;
`endif

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic [1:0]    op_q;
    logic [RW-1:0] rd_q;
    logic [RW-1:0] rn_q;
    logic [RW-1:0] rm_q;

`ifdef CTRL_MOVIMM_EN
    logic [W-1:0]  imm_q;
`else
    // Move-immediate inputs have no function in this build.
    logic          unused_cmd;
    assign unused_cmd = ^{cmd_mov, cmd_imm};
`endif

    // A command is taken only while the controller sits in IDLE.
    assign accept = cmd_valid && (state == IDLE);

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the command fields at the handshake; later cmd_* changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= '0;
            rd_q  <= '0;
            rn_q  <= '0;
            rm_q  <= '0;
`ifdef CTRL_MOVIMM_EN
            imm_q <= '0;
`endif
        end else if (accept) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            rn_q  <= cmd_rn;
            rm_q  <= cmd_rm;
`ifdef CTRL_MOVIMM_EN
            imm_q <= cmd_imm;
`endif
        end
    end

    // Next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (accept) begin
                    // MVN ignores the A operand, so its A-load can be skipped.
                    if ((SKIP_A_MVN != 0) && (cmd_op == 2'b11)) begin
                        state_nxt = LDB;
                    end else begin
                        state_nxt = LDA;
                    end
`ifdef CTRL_MOVIMM_EN
                    if (cmd_mov) begin
                        state_nxt = MOVI;
                    end
`endif
                end
            end
            LDA:     state_nxt = LDB;
            LDB:     state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
`ifdef CTRL_MOVIMM_EN
            MOVI:    state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Moore output decode from the state and the latched fields only.
    always_comb begin
        cmd_ready   = 1'b0;
        readnum     = '0;
        writenum    = '0;
        write       = 1'b0;
        loada       = 1'b0;
        loadb       = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        vsel        = 1'b0;
        ALUop       = 2'b00;
        datapath_in = '0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted so every output reads 0 in reset.
                cmd_ready = reset;
            end
            LDA: begin
                readnum = rn_q;
                loada   = 1'b1;
            end
            LDB: begin
                readnum = rm_q;
                loadb   = 1'b1;
            end
            EXEC: begin
                ALUop = op_q;
                loadc = 1'b1;
                loads = 1'b1;
            end
            WB: begin
                writenum = rd_q;
                write    = 1'b1;
                done     = 1'b1;
                ALUop    = op_q;
            end
`ifdef CTRL_MOVIMM_EN
            MOVI: begin
                writenum    = rd_q;
                vsel        = 1'b1;
                datapath_in = imm_q;
                write       = 1'b1;
                done        = 1'b1;
            end
`endif
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

endmodule
